// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and data ports,
// data first, with a streak limit that guarantees fetch progress.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        istall,
    input  logic        dreq,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        dstall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  dstreak_q, dstreak_d;
    logic        grant, pick_i, idone, ddone;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        grant   = (state_q == IDLE) && (ireq || dreq);
        pick_i  = ireq && (!dreq || dstreak_q == STREAK_MAX);
        state_d = (state_q == IDLE) ? (grant ? (pick_i ? IBUSY : DBUSY) : IDLE)
                                    : (mem_ready ? IDLE : state_q);
    end

    // Request registers load only on a grant and hold until completion.
    always_comb begin
        mem_req_d   = (state_d != IDLE);
        mem_we_d    = grant ? (!pick_i && memwriteM) : ((state_d == IDLE) ? 1'b0 : mem_we_q);
        mem_addr_d  = grant ? (pick_i ? pcF : aluoutM) : mem_addr_q;
        mem_wdata_d = grant ? (pick_i ? 32'd0 : writedataM) : mem_wdata_q;
        dstreak_d   = !grant ? dstreak_q
                    : (pick_i || !ireq) ? 4'd0
                    : (dstreak_q == STREAK_MAX) ? dstreak_q : dstreak_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            dstreak_q   <= 4'd0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dstreak_q   <= dstreak_d;
        end
    end

    always_comb begin
        idone     = (state_q == IBUSY) && mem_ready;
        ddone     = (state_q == DBUSY) && mem_ready;
        instrF    = idone ? mem_rdata : 32'd0;
        readdataM = (ddone && !mem_we_q) ? mem_rdata : 32'd0;
        istall    = ireq && !idone;
        dstall    = dreq && !ddone;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with hand-computed
// expectations, sampled mid-cycle on the falling edge.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq = 1'b0, dreq = 1'b0, memwriteM = 1'b0, mem_ready = 1'b0;
    logic [31:0] pcF = '0, aluoutM = '0, writedataM = '0, mem_rdata = '0;
    logic [31:0] instrF, readdataM, mem_addr, mem_wdata;
    logic        istall, dstall, mem_req, mem_we;
    int          total = 0, bad = 0;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_DSTREAK(4)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .pcF(pcF), .instrF(instrF),
        .istall(istall), .dreq(dreq), .memwriteM(memwriteM), .aluoutM(aluoutM),
        .writedataM(writedataM), .readdataM(readdataM), .dstall(dstall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        total++; if ({mem_req, mem_we} !== 2'b00) begin bad++; $display("FAIL reset_req_we got=%b want=00", {mem_req, mem_we}); end
        total++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_addr_wdata got=%h/%h want=0/0", mem_addr, mem_wdata); end
        total++; if (instrF !== 32'd0 || readdataM !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h/%h want=0/0", instrF, readdataM); end
        ireq = 1'b1; dreq = 1'b1;
        #1;
        total++; if ({istall, dstall} !== 2'b11) begin bad++; $display("FAIL reset_stall_follow got=%b want=11", {istall, dstall}); end
        ireq = 1'b0; dreq = 1'b0;
        #1;
        total++; if ({istall, dstall} !== 2'b00) begin bad++; $display("FAIL reset_stall_low got=%b want=00", {istall, dstall}); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_fetch;
        @(negedge clk);
        ireq = 1'b1; pcF = 32'h40; mem_ready = 1'b0;
        #1;
        total++; if ({istall, mem_req} !== 2'b10) begin bad++; $display("FAIL fetch_req_cycle got=%b want=10", {istall, mem_req}); end
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
        #1;
        total++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h40) begin bad++; $display("FAIL fetch_grant got=%b/%h want=10/40", {mem_req, mem_we}, mem_addr); end
        total++; if (instrF !== 32'h2008_0005 || istall !== 1'b0) begin bad++; $display("FAIL fetch_done got=%h/%b want=20080005/0", instrF, istall); end
        @(negedge clk);
        ireq = 1'b0; mem_ready = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || instrF !== 32'd0) begin bad++; $display("FAIL fetch_after got=%b/%h want=0/0", mem_req, instrF); end
    endtask

    task automatic test_store_wait;
        @(negedge clk);
        dreq = 1'b1; memwriteM = 1'b1; aluoutM = 32'h54; writedataM = 32'd7;
        #1;
        total++; if ({dstall, mem_req} !== 2'b10) begin bad++; $display("FAIL store_req_cycle got=%b want=10", {dstall, mem_req}); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = (k == 3);
            mem_rdata = 32'hffff_ffff;
            #1;
            total++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h54 || mem_wdata !== 32'd7) begin bad++; $display("FAIL store_stable k=%0d got=%b/%h/%h want=11/54/7", k, {mem_req, mem_we}, mem_addr, mem_wdata); end
            total++; if (dstall !== (k != 3) || readdataM !== 32'd0) begin bad++; $display("FAIL store_stall k=%0d got=%b/%h want=%b/0", k, dstall, readdataM, k != 3); end
        end
        @(negedge clk);
        dreq = 1'b0; memwriteM = 1'b0; mem_ready = 1'b0;
        #1;
        total++; if ({mem_req, mem_we} !== 2'b00) begin bad++; $display("FAIL store_after got=%b want=00", {mem_req, mem_we}); end
    endtask

    task automatic test_contention;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ireq = 1'b1; dreq = 1'b1; memwriteM = 1'b0; mem_ready = 1'b1;
                pcF = 32'h100; aluoutM = 32'h200; mem_rdata = 32'd0;
            end
            #1;
            total++; if (mem_req !== i[0]) begin bad++; $display("FAIL cont_req i=%0d got=%b want=%b", i, mem_req, i[0]); end
            if (i[0]) begin
                exp_addr = ((i / 2) % 5 == 4) ? 32'h100 : 32'h200;
                total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL cont_grant i=%0d got=%h want=%h", i, mem_addr, exp_addr); end
            end
        end
    endtask

    task automatic test_streak_reset;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 4) ireq = 1'b0;
            if (i == 6) ireq = 1'b1;
            #1;
            total++; if (mem_req !== i[0]) begin bad++; $display("FAIL streak_req i=%0d got=%b want=%b", i, mem_req, i[0]); end
            if (i[0]) begin
                exp_addr = (i == 15) ? 32'h100 : 32'h200;
                total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL streak_grant i=%0d got=%h want=%h", i, mem_addr, exp_addr); end
            end
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        ireq = 1'b1; dreq = 1'b0; mem_ready = 1'b0; pcF = 32'h100;
        #1;
        total++; if ({istall, mem_req} !== 2'b10) begin bad++; $display("FAIL flush_req got=%b want=10", {istall, mem_req}); end
        @(negedge clk);
        ireq = 1'b0; dreq = 1'b1; aluoutM = 32'h300;
        #1;
        total++; if ({mem_req, istall, dstall} !== 3'b101 || mem_addr !== 32'h100) begin bad++; $display("FAIL flush_busy got=%b/%h want=101/100", {mem_req, istall, dstall}, mem_addr); end
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hdead;
        #1;
        total++; if ({istall, dstall} !== 2'b01 || readdataM !== 32'd0) begin bad++; $display("FAIL flush_done got=%b/%h want=01/0", {istall, dstall}, readdataM); end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++; if ({mem_req, dstall} !== 2'b01) begin bad++; $display("FAIL flush_idle got=%b want=01", {mem_req, dstall}); end
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h1234;
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin bad++; $display("FAIL flush_dgrant got=%b/%h/%b want=1/300/0", mem_req, mem_addr, mem_we); end
        total++; if (readdataM !== 32'h1234 || dstall !== 1'b0) begin bad++; $display("FAIL flush_load got=%h/%b want=1234/0", readdataM, dstall); end
        @(negedge clk);
        dreq = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_load;
        @(negedge clk);
        dreq = 1'b1; memwriteM = 1'b0; aluoutM = 32'h400; writedataM = 32'h99;
        @(negedge clk);
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_wdata !== 32'h99) begin bad++; $display("FAIL rst_load_grant got=%b/%h/%h want=1/400/99", mem_req, mem_addr, mem_wdata); end
        #1;
        reset = 1'b0;
        #1;
        total++; if ({mem_req, mem_we} !== 2'b00 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_async got=%b/%h/%h want=00/0/0", {mem_req, mem_we}, mem_addr, mem_wdata); end
        total++; if (dstall !== 1'b1 || readdataM !== 32'd0) begin bad++; $display("FAIL rst_stall got=%b/%h want=1/0", dstall, readdataM); end
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b want=0", mem_req); end
        reset = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h55;
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin bad++; $display("FAIL rst_regrant got=%b/%h want=1/400", mem_req, mem_addr); end
        total++; if (readdataM !== 32'h55 || dstall !== 1'b0) begin bad++; $display("FAIL rst_load_done got=%h/%b want=55/0", readdataM, dstall); end
        @(negedge clk);
        dreq = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_store_wait;
        test_contention;
        test_streak_reset;
        test_flush;
        test_reset_mid_load;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
